// File: rtl/phys_free_list.sv
// phys_free_list
// Free-list controller for the physical register file sitting behind the
// FRAT/RRAT pair. Rename pulls tags from the head of a circular list in
// program order. Commit pushes released tags onto the tail. A flush rewinds
// the speculative head to the committed head in one cycle. Tags handed out
// but not yet committed stay in storage between cmt_head and spec_head, so
// the rewind needs no copying.
//
// Ports
//   CLK            clock, all state updates on the rising edge
//   RESET          asynchronous, active-low reset
//   alloc_req      Rename wants one tag this cycle
//   alloc_valid    a tag is available and no flush is in progress
//   alloc_tag      tag at the speculative head; meaningful when alloc_valid
//   commit_alloc   a retiring instruction had allocated a tag
//   free_valid     a retiring instruction releases its old mapping
//   free_tag       the tag being released
//   flush          squash all speculative allocations
//   free_count     registered count of allocatable tags
//   empty          no tag is allocatable
//   rename_halt    Rename must hold its queue
//   err_overflow   sticky: a push was attempted while the committed list was full
//   err_underflow  sticky: a commit went past spec_head, or alloc_req while empty

module phys_free_list #(
  parameter int NUM_PHYS = 64,
  parameter int NUM_ARCH = 32,
  parameter int TAG_W    = $clog2(NUM_PHYS),
  parameter int DEPTH    = NUM_PHYS - NUM_ARCH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             alloc_req,
  output logic             alloc_valid,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             commit_alloc,
  input  logic             free_valid,
  input  logic [TAG_W-1:0] free_tag,
  input  logic             flush,
  output logic [TAG_W-1:0] free_count,
  output logic             empty,
  output logic             rename_halt,
  output logic             err_overflow,
  output logic             err_underflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [TAG_W-1:0] tag_mem [DEPTH];

  // Each pointer carries an extra wrap bit above the index bits.
  logic [PTR_W-1:0] spec_head;
  logic [PTR_W-1:0] cmt_head;
  logic [PTR_W-1:0] tail;

  logic             do_alloc;
  logic             push_req;
  logic             do_push;
  logic             cmt_full;
  logic             underflow_evt;
  logic             overflow_evt;
  logic [PTR_W-1:0] tail_next;
  logic [PTR_W-1:0] cmt_next;
  logic [PTR_W-1:0] spec_next;
  logic [PTR_W-1:0] count_next;

  // The outputs are derived from the registered count and the head pointer.
  // A tag freed this cycle is not bypassed to the allocation side.
  always_comb begin
    empty       = (free_count == '0);
    alloc_valid = !empty && !flush;
    alloc_tag   = tag_mem[spec_head[IDX_W-1:0]];
    rename_halt = empty || (alloc_req && (free_count == TAG_W'(1)) && !free_valid);
  end

  // Compute the next values of all pointers. The committed list is full when
  // the index bits match and the wrap bits differ. A push into a full list is
  // dropped. On a flush, the speculative head jumps to the committed head,
  // including any commit that happens in the same cycle.
  always_comb begin
    do_alloc      = alloc_req && alloc_valid;
    push_req      = free_valid && (free_tag != '0);
    cmt_full      = (tail[IDX_W-1:0] == cmt_head[IDX_W-1:0]) &&
                    (tail[IDX_W] != cmt_head[IDX_W]);
    do_push       = push_req && !cmt_full;
    overflow_evt  = push_req && cmt_full;
    underflow_evt = (commit_alloc && (cmt_head == spec_head)) ||
                    (alloc_req && empty);
    tail_next     = tail + PTR_W'(do_push);
    cmt_next      = cmt_head + PTR_W'(commit_alloc);
    spec_next     = flush ? cmt_next : (spec_head + PTR_W'(do_alloc));
    count_next    = tail_next - spec_next;
  end

  // Update the pointers, the registered free count and the sticky error flags.
  // At reset, the tail sits one full lap ahead of both heads, so all DEPTH
  // entries are allocatable.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      spec_head     <= '0;
      cmt_head      <= '0;
      tail          <= PTR_W'(DEPTH);
      free_count    <= TAG_W'(DEPTH);
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      spec_head  <= spec_next;
      cmt_head   <= cmt_next;
      tail       <= tail_next;
      free_count <= TAG_W'(count_next);
      if (overflow_evt)  err_overflow  <= 1'b1;
      if (underflow_evt) err_underflow <= 1'b1;
    end
  end

  // Storage. At reset, it holds the physical tags that are not initially
  // mapped: NUM_ARCH upward. Released tags are written at the tail.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) tag_mem[i] <= TAG_W'(NUM_ARCH + i);
    end else if (do_push) begin
      tag_mem[tail[IDX_W-1:0]] <= free_tag;
    end
  end

endmodule
